// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: FSM states, forwarding
// select codes and the in-flight destination scoreboard entry.
package hazard_ctrl_pkg;

  localparam int REG_SEL_W = 5;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [REG_SEL_W-1:0] rd_sel;
    logic                 load;
  } sb_entry_t;

  // A load sitting in EX has no result yet, so only MEM may supply it.
  function automatic logic [1:0] fwd_pick(sb_entry_t ex, sb_entry_t mem,
                                          logic used, logic [REG_SEL_W-1:0] sel);
    if (!used || sel == '0) return FWD_REG;
    if (ex.valid && !ex.load && ex.rd_sel == sel) return FWD_EX;
    if (mem.valid && mem.rd_sel == sel) return FWD_MEM;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/memory handshake and pipeline control bundle between the pipeline
// (master) and the hazard controller (slave).
interface hazard_ctrl_if #(parameter int SEL_W = 5);

  logic             id_valid;
  logic [SEL_W-1:0] id_rs1_sel;
  logic [SEL_W-1:0] id_rs2_sel;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [SEL_W-1:0] id_rd_sel;
  logic             id_rd_wr;
  logic             id_load;
  logic             id_j_type;
  logic             mem_req;
  logic             mem_ack;

  logic             halt_front;
  logic             halt_all;
  logic             bubble_ex;
  logic             flush_front;
  logic [1:0]       fwd_rs1;
  logic [1:0]       fwd_rs2;
  logic [1:0]       state_dbg;

  modport master (
    output id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
           id_rd_sel, id_rd_wr, id_load, id_j_type, mem_req, mem_ack,
    input  halt_front, halt_all, bubble_ex, flush_front, fwd_rs1, fwd_rs2,
           state_dbg
  );

  modport slave (
    input  id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
           id_rd_sel, id_rd_wr, id_load, id_j_type, mem_req, mem_ack,
    output halt_front, halt_all, bubble_ex, flush_front, fwd_rs1, fwd_rs2,
           state_dbg
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Two-entry EX/MEM destination tracker with forwarding selects and load-use
// detection for the instruction currently in decode.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int SEL_W = REG_SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             kill,
  input  logic             id_valid,
  input  logic [SEL_W-1:0] id_rs1_sel,
  input  logic [SEL_W-1:0] id_rs2_sel,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [SEL_W-1:0] id_rd_sel,
  input  logic             id_rd_wr,
  input  logic             id_load,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic             lu_hit
);

  sb_entry_t ex_q;
  sb_entry_t mem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!hold) begin
      mem_q        <= ex_q;
      ex_q.valid   <= id_valid & id_rd_wr & (id_rd_sel != '0) & ~kill;
      ex_q.rd_sel  <= id_rd_sel;
      ex_q.load    <= id_load;
    end
  end

  assign fwd_rs1 = fwd_pick(ex_q, mem_q, id_rs1_used, id_rs1_sel);
  assign fwd_rs2 = fwd_pick(ex_q, mem_q, id_rs2_used, id_rs2_sel);

  // A valid entry never holds x0, so no separate zero-select guard is needed.
  assign lu_hit = id_valid & ex_q.valid & ex_q.load &
                  ((id_rs1_used & (id_rs1_sel == ex_q.rd_sel)) |
                   (id_rs2_used & (id_rs2_sel == ex_q.rd_sel)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory-wait freeze, post-jump flush and
// load-use bubbles around the scoreboard's forwarding logic.
//
// state       | meaning
// ST_RUN      | normal issue; may start a stall, flush or bubble this cycle
// ST_LU_STALL | extra load-use bubbles while cnt_q counts down
// ST_MEM_WAIT | whole pipe frozen until mem_ack; resumes ret_q
// ST_FLUSH    | invalidating wrong-path fetches while cnt_q counts down
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int SEL_W        = REG_SEL_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int LU_STALL     = 1
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave bus
);

  state_t           state_q;
  state_t           ret_q;
  logic [CNT_W-1:0] cnt_q;

  logic halt_front_c;
  logic halt_all_c;
  logic bubble_c;
  logic flush_c;
  logic lu_hit;
  logic jump;
  logic mem_stall;
  logic mem_done;

  assign mem_stall = bus.mem_req & ~bus.mem_ack;
  assign mem_done  = bus.mem_req & bus.mem_ack;
  assign jump      = bus.id_valid & bus.id_j_type;

  hazard_scoreboard #(.SEL_W(SEL_W)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .hold        (halt_all_c),
    .kill        (bubble_c | flush_c),
    .id_valid    (bus.id_valid),
    .id_rs1_sel  (bus.id_rs1_sel),
    .id_rs2_sel  (bus.id_rs2_sel),
    .id_rs1_used (bus.id_rs1_used),
    .id_rs2_used (bus.id_rs2_used),
    .id_rd_sel   (bus.id_rd_sel),
    .id_rd_wr    (bus.id_rd_wr),
    .id_load     (bus.id_load),
    .fwd_rs1     (bus.fwd_rs1),
    .fwd_rs2     (bus.fwd_rs2),
    .lu_hit      (lu_hit)
  );

  always_comb begin
    halt_front_c = 1'b0;
    halt_all_c   = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          halt_all_c   = 1'b1;
          halt_front_c = 1'b1;
        end else if (jump) begin
          flush_c = 1'b1;
        end else if (lu_hit) begin
          halt_front_c = 1'b1;
          bubble_c     = 1'b1;
        end
      end
      ST_LU_STALL: begin
        halt_front_c = 1'b1;
        if (mem_stall) halt_all_c = 1'b1;
        else           bubble_c   = 1'b1;
      end
      // The ack cycle releases the pipe; the resumed state acts from the next cycle.
      ST_MEM_WAIT: begin
        if (!mem_done) begin
          halt_all_c   = 1'b1;
          halt_front_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          halt_all_c   = 1'b1;
          halt_front_c = 1'b1;
        end else begin
          flush_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            state_q <= ST_MEM_WAIT;
            ret_q   <= ST_RUN;
          end else if (jump) begin
            cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
            state_q <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end else if (lu_hit && LU_STALL > 1) begin
            cnt_q   <= CNT_W'(LU_STALL - 1);
            state_q <= ST_LU_STALL;
          end
        end
        ST_LU_STALL, ST_FLUSH: begin
          if (mem_stall) begin
            state_q <= ST_MEM_WAIT;
            ret_q   <= state_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_q <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_done) state_q <= ret_q;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.halt_front  = halt_front_c & ~reset;
  assign bus.halt_all    = halt_all_c & ~reset;
  assign bus.bubble_ex   = bubble_c & ~reset;
  assign bus.flush_front = flush_c & ~reset;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// reset/ack corner sequences, then randomized traffic against a cycle model.
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int LU_STALL     = 1;
  localparam int NV           = 18;
  localparam int NRAND        = 3000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.SEL_W(5)) bus ();

  hazard_ctrl #(.SEL_W(5), .FLUSH_CYCLES(FLUSH_CYCLES), .LU_STALL(LU_STALL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v, rs1, rs2, u1, u2, rd, wr, ld, j, mreq, mack;
    int hf, ha, bub, fl, f1, f2, st;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, int hf, int ha, int bub, int fl,
                            int f1, int f2, int st);
    chk({tag, ".halt_front"},  int'(bus.halt_front),  hf);
    chk({tag, ".halt_all"},    int'(bus.halt_all),    ha);
    chk({tag, ".bubble_ex"},   int'(bus.bubble_ex),   bub);
    chk({tag, ".flush_front"}, int'(bus.flush_front), fl);
    chk({tag, ".fwd_rs1"},     int'(bus.fwd_rs1),     f1);
    chk({tag, ".fwd_rs2"},     int'(bus.fwd_rs2),     f2);
    chk({tag, ".state_dbg"},   int'(bus.state_dbg),   st);
  endtask

  task automatic drive(vec_t x);
    bus.id_valid    = (x.v != 0);
    bus.id_rs1_sel  = 5'(x.rs1);
    bus.id_rs2_sel  = 5'(x.rs2);
    bus.id_rs1_used = (x.u1 != 0);
    bus.id_rs2_used = (x.u2 != 0);
    bus.id_rd_sel   = 5'(x.rd);
    bus.id_rd_wr    = (x.wr != 0);
    bus.id_load     = (x.ld != 0);
    bus.id_j_type   = (x.j != 0);
    bus.mem_req     = (x.mreq != 0);
    bus.mem_ack     = (x.mack != 0);
  endtask

  // Reference model: in-flight destinations plus remaining-work counters.
  typedef struct {bit v; int rd; bit ld;} ment_t;
  ment_t m_ex, m_mem;
  bit    m_wait;
  int    m_flush_left, m_bub_left;

  function automatic int mfwd(bit used, int sel);
    if (!used || sel == 0) return 0;
    if (m_ex.v && !m_ex.ld && m_ex.rd == sel) return 1;
    if (m_mem.v && m_mem.rd == sel) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex = '{0, 0, 0};
    m_mem = '{0, 0, 0};
    m_wait = 0;
    m_flush_left = 0;
    m_bub_left = 0;
  endtask

  // Compare current outputs against the model, then advance the model one clock.
  task automatic model_step(string tag);
    bit v, u1, u2, wr, ld, j, rq, ak;
    int rs1, rs2, rd;
    int hf, ha, bub, fl, st;
    bit lu, stall_req;
    v = bus.id_valid; u1 = bus.id_rs1_used; u2 = bus.id_rs2_used;
    wr = bus.id_rd_wr; ld = bus.id_load; j = bus.id_j_type;
    rq = bus.mem_req; ak = bus.mem_ack;
    rs1 = int'(bus.id_rs1_sel); rs2 = int'(bus.id_rs2_sel); rd = int'(bus.id_rd_sel);
    hf = 0; ha = 0; bub = 0; fl = 0;
    stall_req = rq && !ak;
    lu = v && m_ex.v && m_ex.ld && ((u1 && rs1 == m_ex.rd) || (u2 && rs2 == m_ex.rd));
    st = m_wait ? 2 : (m_flush_left > 0 ? 3 : (m_bub_left > 0 ? 1 : 0));
    if (m_wait) begin
      if (rq && ak) m_wait = 0;
      else begin ha = 1; hf = 1; end
    end else if (stall_req) begin
      ha = 1; hf = 1; m_wait = 1;
    end else if (m_flush_left > 0) begin
      fl = 1; m_flush_left--;
    end else if (m_bub_left > 0) begin
      hf = 1; bub = 1; m_bub_left--;
    end else if (v && j) begin
      fl = 1; m_flush_left = FLUSH_CYCLES - 1;
    end else if (lu) begin
      hf = 1; bub = 1; m_bub_left = LU_STALL - 1;
    end
    check_outs(tag, hf, ha, bub, fl, mfwd(u1, rs1), mfwd(u2, rs2), st);
    if (ha == 0) begin
      m_mem = m_ex;
      m_ex.v = v && wr && rd != 0 && !bub && !fl;
      m_ex.rd = rd;
      m_ex.ld = ld;
    end
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    //            v rs1 rs2 u1 u2 rd wr ld j rq ak | hf ha bb fl f1 f2 st
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{1, 5, 5, 1, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0};
    vecs[4]  = '{1, 5, 0, 1, 1, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 2, 0, 0};
    vecs[5]  = '{1, 0, 7, 0, 1, 8, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 7, 0, 1, 8, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 0, 2};
    vecs[9]  = '{1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 1, 0, 2};
    vecs[10] = '{1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 2};
    vecs[11] = '{1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 2, 0, 0};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 3};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 2};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 2};
    vecs[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 3};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    idle = vecs[0];

    // Reset held with a pending memory request: every output must stay low.
    reset = 1'b1;
    drive(idle);
    bus.mem_req = 1'b1;
    @(negedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(idle);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].hf, vecs[i].ha, vecs[i].bub,
                 vecs[i].fl, vecs[i].f1, vecs[i].f2, vecs[i].st);
    end

    // Ack without request is ignored, then async reset lands during MEM_WAIT.
    @(negedge clk);
    drive(idle);
    bus.id_valid = 1'b1; bus.id_rd_sel = 5'd9; bus.id_rd_wr = 1'b1;
    #1;
    check_outs("seq_x9", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(idle);
    bus.mem_req = 1'b1;
    #1;
    check_outs("seq_req", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(idle);
    bus.mem_ack = 1'b1;
    #1;
    check_outs("seq_ack_noreq", 1, 1, 0, 0, 0, 0, 2);
    @(negedge clk);
    drive(idle);
    bus.mem_req = 1'b1;
    bus.id_valid = 1'b1; bus.id_rs1_sel = 5'd9; bus.id_rs1_used = 1'b1;
    #1;
    check_outs("seq_wait", 1, 1, 0, 0, 1, 0, 2);
    #1;
    reset = 1'b1;
    #1;
    check_outs("seq_async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    check_outs("seq_after_rst", 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional single-cycle resets.
    @(negedge clk);
    reset = 1'b1;
    drive(idle);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < NRAND; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      bus.id_valid    = ($urandom_range(0, 9) < 8);
      bus.id_rs1_sel  = 5'($urandom_range(0, 3));
      bus.id_rs2_sel  = 5'($urandom_range(0, 3));
      bus.id_rs1_used = 1'($urandom_range(0, 1));
      bus.id_rs2_used = 1'($urandom_range(0, 1));
      bus.id_rd_sel   = 5'($urandom_range(0, 3));
      bus.id_rd_wr    = ($urandom_range(0, 3) != 0);
      bus.id_load     = ($urandom_range(0, 9) < 3);
      bus.id_j_type   = ($urandom_range(0, 99) < 8);
      bus.mem_req     = ($urandom_range(0, 3) == 0);
      bus.mem_ack     = 1'($urandom_range(0, 1));
      #1;
      if (reset) begin
        model_reset();
        check_outs($sformatf("rnd%0d_rst", n), 0, 0, 0, 0, 0, 0, 0);
      end else begin
        model_step($sformatf("rnd%0d", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the execute stage and its neighbours.
- Tracks destination registers in flight in EX and MEM, and drives rs1/rs2 forwarding selects into execute.
- Stalls the front end on load-use hazards and freezes the whole pipe while a memory access is unacknowledged.
- After a jump, invalidates wrong-path fetches for a fixed count.

Parameters:
- SEL_W, 5, register-select width.
- FLUSH_CYCLES, 2, front-end flush length after a jump (matches execute's two-cycle squash).
- LU_STALL, 1, bubbles inserted per load-use hazard (1..3).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1_sel  in  SEL_W  decode source 1.
- id_rs2_sel  in  SEL_W  decode source 2.
- id_rs1_used  in  1  source 1 is read.
- id_rs2_used  in  1  source 2 is read.
- id_rd_sel  in  SEL_W  decode destination.
- id_rd_wr  in  1  instruction writes rd.
- id_load  in  1  instruction is a load (mem_rd_en).
- id_j_type  in  1  instruction is a jump.
- mem_req  in  1  MEM stage has an access outstanding this cycle.
- mem_ack  in  1  memory completes the access this cycle.
- halt_front  out  1  hold IF/ID registers.
- halt_all  out  1  hold every stage (execute's halt).
- bubble_ex  out  1  load a nop into EX (zero rd_sel, mem enables).
- flush_front  out  1  invalidate IF/ID contents.
- fwd_rs1  out  2  0 = regfile, 1 = EX result, 2 = MEM result.
- fwd_rs2  out  2  same encoding for rs2.
- state_dbg  out  2  current FSM state.

Behaviour:
- Reset is asynchronous and active-high; reset dominates all other events.
- Values on reset:
  - state = RUN, counters = 0, both scoreboard entries invalid.
  - All outputs are 0 while reset is held.
- Scoreboard: two entries, EX and MEM, each {valid, rd_sel, load}.
  - When halt_all = 0: MEM <= EX, and EX <= the ID fields.
  - EX captures valid = id_valid & id_rd_wr & (id_rd_sel != 0) & !bubble_ex & !flush_front.
  - When halt_all = 1: both entries hold.
- Forwarding (combinational, per source, evaluated only if that source is used and its sel != 0):
  - EX match with a non-load entry gives 1.
  - Otherwise a MEM match gives 2.
  - Otherwise 0.
  - EX has priority over MEM.
  - A load in EX never forwards.
- Load-use hazard (lu_hit): id_valid, EX valid & load, and EX rd_sel equals a used source.
- FSM states: RUN, LU_STALL, MEM_WAIT, FLUSH. Priority: MEM_WAIT > FLUSH > load-use.
- RUN:
  - mem_req & !mem_ack: halt_all = 1 combinationally; next state MEM_WAIT; ret = RUN.
  - Else id_valid & id_j_type: flush_front = 1 this cycle; cnt <= FLUSH_CYCLES-1; next state FLUSH if cnt > 0, else RUN.
  - Else lu_hit: halt_front = 1 and bubble_ex = 1 this cycle. If LU_STALL > 1, cnt <= LU_STALL-1 and next state is LU_STALL.
  - Else all stall outputs are 0.
- LU_STALL:
  - halt_front = 1, bubble_ex = 1, cnt decrements.
  - Go to RUN when cnt reaches 1 and is consumed.
  - mem_req & !mem_ack preempts: go to MEM_WAIT, ret = LU_STALL, cnt preserved.
- MEM_WAIT:
  - halt_all = 1 and halt_front = 1; scoreboard and cnt frozen.
  - When mem_ack = 1: halt_all drops in that same cycle and the FSM returns to ret.
  - mem_ack without mem_req is ignored.
- FLUSH:
  - flush_front = 1, cnt decrements, return to RUN when it expires.
  - ID fields are ignored, so no new jump or lu_hit is taken.
  - Preempted by MEM_WAIT with ret = FLUSH, cnt preserved.
- Same-cycle mem_req & mem_ack is a zero-wait access: no stall, stays in RUN.
- halt_all = 1 implies halt_front = 1.
- bubble_ex and flush_front are never asserted while halt_all = 1.
- Reset mid-stall or mid-flush returns immediately to RUN; the scoreboard clears.
- state_dbg encoding: RUN = 0, LU_STALL = 1, MEM_WAIT = 2, FLUSH = 3.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - FWD_REG = 0, FWD_EX = 1, FWD_MEM = 2.
  - The scoreboard entry struct.
- One natural sub-module: hazard_scoreboard.
  - Contains the two-entry shift register, the forwarding compare and lu_hit.
  - The FSM stays in hazard_ctrl.

Test Plan:
- Forwarding, EX: an add writes x5 and is followed by a use of x5 as rs1 → next cycle fwd_rs1 = 1, no stall.
- Forwarding, priority: x5 is in MEM and x5 is also in EX → fwd = 1. x0 destination → fwd = 0 and the scoreboard entry is invalid.
- Load-use: a load to x7 in EX with ID reading x7 as rs2 → one cycle of halt_front = 1 and bubble_ex = 1; the following cycle fwd_rs2 = 2 and the FSM is in RUN.
- Memory wait: mem_req held with mem_ack delayed 3 cycles → halt_all = 1 for 3 cycles and drops in the ack cycle; scoreboard unchanged. Same-cycle ack → no halt.
- Jump: id_j_type → flush_front = 1 for 2 consecutive cycles; a mem stall in the second cycle resumes FLUSH with 1 cycle remaining after ack.
- Reset: reset asserted asynchronously during MEM_WAIT → all outputs 0 immediately, state_dbg = 0, scoreboard empty after release.
